commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: turns retired writeback/branch/store events into
// timestamped trace records, queues them in a show-ahead FIFO, and stops
// accepting events once the finish store has been seen and drained.
module commit_trace_buffer #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 16,
  parameter logic [XLEN-1:0] FINISH_ADDR = XLEN'(32'h1000_0000)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // register writeback / jump retirement
  input  logic                       wb_valid,
  input  logic                       wb_pc_load,
  input  logic [XLEN-1:0]            wb_tag,
  input  logic [XLEN-1:0]            wb_instr,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [XLEN-1:0]            wb_pc,
  // conditional branch resolution
  input  logic                       br_valid,
  input  logic                       br_taken,
  input  logic [XLEN-1:0]            br_tag,
  input  logic [XLEN-1:0]            br_instr,
  input  logic [XLEN-1:0]            br_pc,
  // store commit
  input  logic                       st_valid,
  input  logic [XLEN-1:0]            st_tag,
  input  logic [XLEN-1:0]            st_instr,
  input  logic [XLEN-1:0]            st_addr,
  input  logic [XLEN-1:0]            st_data,
  // trace record stream
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [1:0]                 trc_kind,
  output logic [31:0]                trc_cycle,
  output logic [XLEN-1:0]            trc_tag,
  output logic [XLEN-1:0]            trc_instr,
  output logic [XLEN-1:0]            trc_a,
  output logic [XLEN-1:0]            trc_b,
  output logic [XLEN-1:0]            trc_c,
  // status
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic                       done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_JUMP   = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;
  localparam logic [1:0] KIND_STORE  = 2'd3;

  typedef struct packed {
    logic [1:0]      kind;
    logic [31:0]     cycle;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] c;
  } rec_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FINISHING = 2'd1,
    ST_DONE      = 2'd2
  } state_t;

  rec_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [31:0]   cycle_q;
  logic          overflow_q;
  logic [15:0]   drop_q;
  logic          done_q;
  state_t        state;
  state_t        next_state;

  logic [1:0]    n_ev;
  logic [1:0]    n_push;
  logic [CW-1:0] free;
  logic          has_ev;
  logic          push;
  logic          drop;
  logic          pop;
  logic          finish_hit;
  logic [PW-1:0] idx_wb;
  logic [PW-1:0] idx_br;
  logic [PW-1:0] idx_st;
  rec_t          rec_wb;
  rec_t          rec_br;
  rec_t          rec_st;
  rec_t          head;

  // Admission: all-or-nothing against the pre-pop free space, only while running
  always_comb begin
    n_ev       = 2'({1'b0, wb_valid}) + 2'({1'b0, br_valid}) + 2'({1'b0, st_valid});
    free       = CW'(DEPTH) - count_q;
    has_ev     = (n_ev != 2'd0);
    push       = (state == ST_RUN) && has_ev && (free >= CW'(n_ev));
    drop       = (state == ST_RUN) && has_ev && (free <  CW'(n_ev));
    n_push     = push ? n_ev : 2'd0;
    pop        = (count_q != CW'(0)) && trc_ready;
    finish_hit = push && st_valid && (st_addr == FINISH_ADDR);
    idx_wb     = wr_ptr;
    idx_br     = wr_ptr + PW'(wb_valid);
    idx_st     = wr_ptr + PW'(wb_valid) + PW'(br_valid);
  end

  // Record formatting for each event source
  always_comb begin
    rec_wb       = '0;
    rec_wb.kind  = wb_pc_load ? KIND_JUMP : KIND_REG;
    rec_wb.cycle = cycle_q;
    rec_wb.tag   = wb_tag;
    rec_wb.instr = wb_instr;
    rec_wb.a     = XLEN'(wb_rd);
    rec_wb.b     = wb_data;
    rec_wb.c     = wb_pc_load ? wb_pc : '0;

    rec_br       = '0;
    rec_br.kind  = KIND_BRANCH;
    rec_br.cycle = cycle_q;
    rec_br.tag   = br_tag;
    rec_br.instr = br_instr;
    rec_br.a     = XLEN'(br_taken);
    rec_br.b     = '0;
    rec_br.c     = br_taken ? br_pc : '0;

    rec_st       = '0;
    rec_st.kind  = KIND_STORE;
    rec_st.cycle = cycle_q;
    rec_st.tag   = st_tag;
    rec_st.instr = st_instr;
    rec_st.a     = st_addr;
    rec_st.b     = st_data;
    rec_st.c     = '0;
  end

  // Record storage, written into consecutive slots in wb, br, st order
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      if (wb_valid) mem[idx_wb] <= rec_wb;
      if (br_valid) mem[idx_br] <= rec_br;
      if (st_valid) mem[idx_st] <= rec_st;
    end
  end

  // FIFO bookkeeping, cycle stamp, overflow tracking and done flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop);
      wr_ptr  <= wr_ptr + PW'(n_push);
      count_q <= count_q + CW'(n_push) - CW'(pop);
      cycle_q <= cycle_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      done_q <= (next_state == ST_DONE);
    end
  end

  // Run-state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  // Run-state transitions: finish store accepted, then wait for drain
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:       if (finish_hit) next_state = ST_FINISHING;
      ST_FINISHING: if (count_q == CW'(0)) next_state = ST_DONE;
      ST_DONE:      next_state = ST_DONE;
      default:      next_state = ST_RUN;
    endcase
  end

  // Show-ahead head presentation, zeroed while empty
  always_comb begin
    head      = mem[rd_ptr];
    trc_valid = (count_q != CW'(0));
    trc_kind  = trc_valid ? head.kind  : 2'd0;
    trc_cycle = trc_valid ? head.cycle : 32'd0;
    trc_tag   = trc_valid ? head.tag   : '0;
    trc_instr = trc_valid ? head.instr : '0;
    trc_a     = trc_valid ? head.a     : '0;
    trc_b     = trc_valid ? head.b     : '0;
    trc_c     = trc_valid ? head.c     : '0;
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign done     = done_q;

endmodule
